// File: rtl/gray_bcd_pkg.sv
`default_nettype none
// =============================================================================
// Package     : gray_bcd_pkg
// Description : Shared state encoding, digit constants and Gray-code validity
//               helper for the Gray-to-BCD stream decoder.
// Revision    : 1.0 - initial release
// =============================================================================
package gray_bcd_pkg;

    localparam int          DIGIT_W        = 4;
    localparam int          BCD_MAX        = 9;
    localparam logic [3:0]  INVALID_NIBBLE = 4'hF;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DECODE = 2'd1,
        OUTPUT = 2'd2
    } gray_bcd_state_e;

    // A Gray code is a legal digit when its binary value lies in 0..9.
    function automatic logic is_valid_gray_digit(input logic [3:0] gray);
        logic [3:0] bin;
        bin[3] = gray[3];
        bin[2] = bin[3] ^ gray[2];
        bin[1] = bin[2] ^ gray[1];
        bin[0] = bin[1] ^ gray[0];
        return (int'(bin) <= BCD_MAX);
    endfunction

endpackage
`default_nettype wire

// File: rtl/gray_serial_decoder.sv
`default_nettype none
// =============================================================================
// Module      : gray_serial_decoder
// Description : Bit-serial, MSB-first Gray-to-binary conversion of one 4-bit
//               code over four cycles; done pulses on the bit-0 cycle.
// Revision    : 1.0 - initial release
// =============================================================================
module gray_serial_decoder
    import gray_bcd_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       load,
    input  logic [3:0] gray,
    output logic       done,
    output logic [3:0] bin,
    output logic       invalid
);

    logic [3:0] r_gray;
    logic [3:0] r_bin;
    logic [1:0] r_cnt;
    logic       r_busy;
    logic       r_prev;
    logic       w_bit;

    // r_prev starts at 0 so the first step yields b3 = g3.
    assign w_bit = r_gray[r_cnt] ^ r_prev;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_gray <= 4'd0;
            r_bin  <= 4'd0;
            r_cnt  <= 2'd0;
            r_busy <= 1'b0;
            r_prev <= 1'b0;
        end else if (load) begin
            r_gray <= gray;
            r_bin  <= 4'd0;
            r_cnt  <= 2'd3;
            r_busy <= 1'b1;
            r_prev <= 1'b0;
        end else if (r_busy) begin
            r_bin[r_cnt] <= w_bit;
            r_prev       <= w_bit;
            r_cnt        <= r_cnt - 2'd1;
            if (r_cnt == 2'd0) begin
                r_busy <= 1'b0;
            end
        end
    end

    // Bit 0 is forwarded combinationally so the digit is usable on the done cycle.
    assign done    = r_busy && (r_cnt == 2'd0);
    assign bin     = done ? {r_bin[3:1], w_bit} : r_bin;
    assign invalid = !is_valid_gray_digit(r_gray);

endmodule
`default_nettype wire

// File: rtl/gray_to_bcd_stream_decoder.sv
`default_nettype none
// =============================================================================
// Module      : gray_to_bcd_stream_decoder
// Description : Streams Gray-coded digits in, packs decoded digits into a BCD
//               word with count and sticky error, and hands the word out over
//               valid/ready. Define GRAY_BCD_BIN_OUT_EN to add a binary output.
// Revision    : 1.0 - initial release
// =============================================================================
module gray_to_bcd_stream_decoder
    import gray_bcd_pkg::*;
#(
    parameter  int NUM_DIGITS = 4,
    localparam int CNT_W      = $clog2(NUM_DIGITS + 1)
`ifdef GRAY_BCD_BIN_OUT_EN
    ,
    localparam int BIN_W      = $clog2(10 ** NUM_DIGITS)
`endif
)(
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [3:0]                    in_gray,
    input  logic                          in_last,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [DIGIT_W*NUM_DIGITS-1:0] out_bcd,
    output logic [CNT_W-1:0]              out_ndigits,
    output logic                          out_err
`ifdef GRAY_BCD_BIN_OUT_EN
    ,
    output logic [BIN_W-1:0]              out_bin
`endif
);

    localparam int         c_WORD_W    = DIGIT_W * NUM_DIGITS;
    localparam logic [1:0] c_ST_IDLE   = IDLE;
    localparam logic [1:0] c_ST_DECODE = DECODE;
    localparam logic [1:0] c_ST_OUTPUT = OUTPUT;

    logic [1:0]          r_state;
    logic                r_last;
    logic [c_WORD_W-1:0] r_word;
    logic [CNT_W-1:0]    r_count;
    logic                r_err;

    logic                w_in_fire;
    logic                w_dec_done;
    logic [3:0]          w_dec_bin;
    logic                w_dec_invalid;
    logic [3:0]          w_nibble;
    logic [c_WORD_W-1:0] w_word_next;
    logic [CNT_W-1:0]    w_count_inc;
    logic                w_complete;

    assign in_ready  = (r_state == c_ST_IDLE);
    assign out_valid = (r_state == c_ST_OUTPUT);
    assign w_in_fire = in_valid && in_ready;

    gray_serial_decoder u_dec (
        .clk     (clk),
        .rst_n   (rst_n),
        .load    (w_in_fire),
        .gray    (in_gray),
        .done    (w_dec_done),
        .bin     (w_dec_bin),
        .invalid (w_dec_invalid)
    );

    assign w_nibble    = w_dec_invalid ? INVALID_NIBBLE : w_dec_bin;
    assign w_count_inc = r_count + CNT_W'(1);
    assign w_complete  = r_last || (w_count_inc == CNT_W'(NUM_DIGITS));

    generate
        if (NUM_DIGITS == 1) begin : g_word_single
            assign w_word_next = w_nibble;
        end else begin : g_word_multi
            assign w_word_next = {r_word[c_WORD_W-DIGIT_W-1:0], w_nibble};
        end
    endgenerate

`ifdef GRAY_BCD_BIN_OUT_EN
    logic [BIN_W-1:0] r_acc;
    logic [BIN_W-1:0] w_acc_next;

    assign w_acc_next = r_acc * BIN_W'(10) + BIN_W'(w_nibble);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_acc <= '0;
        end else if (r_state == c_ST_DECODE && w_dec_done) begin
            r_acc <= w_acc_next;
        end else if (r_state == c_ST_OUTPUT && out_ready) begin
            r_acc <= '0;
        end
    end

    assign out_bin = r_err ? '0 : r_acc;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= c_ST_IDLE;
            r_last  <= 1'b0;
            r_word  <= '0;
            r_count <= '0;
            r_err   <= 1'b0;
        end else begin
            case (r_state)
                c_ST_IDLE: begin
                    if (w_in_fire) begin
                        r_last  <= in_last;
                        r_state <= c_ST_DECODE;
                    end
                end
                c_ST_DECODE: begin
                    if (w_dec_done) begin
                        r_word  <= w_word_next;
                        r_count <= w_count_inc;
                        r_err   <= r_err | w_dec_invalid;
                        r_state <= w_complete ? c_ST_OUTPUT : c_ST_IDLE;
                    end
                end
                c_ST_OUTPUT: begin
                    if (out_ready) begin
                        r_word  <= '0;
                        r_count <= '0;
                        r_err   <= 1'b0;
                        r_last  <= 1'b0;
                        r_state <= c_ST_IDLE;
                    end
                end
                default: r_state <= c_ST_IDLE;
            endcase
        end
    end

    assign out_bcd     = r_word;
    assign out_ndigits = r_count;
    assign out_err     = r_err;

endmodule
`default_nettype wire

// File: tb/tb_gray_to_bcd_stream_decoder.sv
`default_nettype none
// =============================================================================
// Module      : tb_gray_to_bcd_stream_decoder
// Description : Directed self-checking bench for gray_to_bcd_stream_decoder.
// Revision    : 1.0 - initial release
// =============================================================================
module tb_gray_to_bcd_stream_decoder;

    localparam int NUM_DIGITS = 4;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  in_gray;
    logic        in_last;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_bcd;
    logic [2:0]  out_ndigits;
    logic        out_err;
`ifdef GRAY_BCD_BIN_OUT_EN
    logic [13:0] out_bin;
`endif

    int n_asserts = 0;
    int n_fail    = 0;

    gray_to_bcd_stream_decoder #(.NUM_DIGITS(NUM_DIGITS)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_gray     (in_gray),
        .in_last     (in_last),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_bcd     (out_bcd),
        .out_ndigits (out_ndigits),
        .out_err     (out_err)
`ifdef GRAY_BCD_BIN_OUT_EN
        ,
        .out_bin     (out_bin)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_asserts++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    // Present a digit and hold it until accepted; returns just after the handshake edge.
    task automatic send_digit(input logic [3:0] g, input logic last);
        int n;
        n = 0;
        @(negedge clk);
        in_valid = 1'b1;
        in_gray  = g;
        in_last  = last;
        while (!in_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) begin
            check("handshake_timeout", 64'd0, 64'd1);
        end else begin
            @(posedge clk);
        end
        #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    // Cycles from handshake cycle T until the named signal is high (T counts as 0).
    task automatic measure_out_valid(output int lat);
        lat = 1;
        @(negedge clk);
        while (!out_valid && lat < 50) begin
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic measure_in_ready(output int lat);
        lat = 1;
        @(negedge clk);
        while (!in_ready && lat < 50) begin
            @(negedge clk);
            lat++;
        end
    endtask

    // Wait for a word, check it, optionally hold backpressure, then accept it.
    task automatic recv(input string tag, input logic [15:0] exp_bcd, input logic [2:0] exp_nd,
                        input logic exp_err, input logic [13:0] exp_bin, input int hold);
        int n;
        n = 0;
        @(negedge clk);
        while (!out_valid && n < 100) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_valid"}, 64'(out_valid), 64'd1);
        check({tag, "_bcd"},   64'(out_bcd), 64'(exp_bcd));
        check({tag, "_nd"},    64'(out_ndigits), 64'(exp_nd));
        check({tag, "_err"},   64'(out_err), 64'(exp_err));
`ifdef GRAY_BCD_BIN_OUT_EN
        check({tag, "_bin"},   64'(out_bin), 64'(exp_bin));
`else
        if (exp_bin != 14'd0 && exp_err) $display("note: unexpected binary expectation on error word");
`endif
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            check({tag, "_hold_valid"}, 64'(out_valid), 64'd1);
            check({tag, "_hold_bcd"},   64'(out_bcd), 64'(exp_bcd));
            check({tag, "_hold_ready"}, 64'(in_ready), 64'd0);
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        @(negedge clk);
        check({tag, "_released"}, 64'(out_valid), 64'd0);
        check({tag, "_ready_after"}, 64'(in_ready), 64'd1);
        check({tag, "_nd_cleared"}, 64'(out_ndigits), 64'd0);
    endtask

    initial begin
        int lat;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_gray   = 4'd0;
        in_last   = 1'b0;
        out_ready = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_in_ready",  64'(in_ready), 64'd1);
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_out_bcd",   64'(out_bcd), 64'd0);
        check("rst_out_nd",    64'(out_ndigits), 64'd0);
        check("rst_out_err",   64'(out_err), 64'd0);
        rst_n = 1'b1;

        // Single digit 1101 -> 9, out_valid 5 cycles after handshake
        send_digit(4'b1101, 1'b1);
        measure_out_valid(lat);
        check("single_latency", 64'(lat), 64'd5);
        // Backpressure with a new digit waiting on the input
        in_valid = 1'b1;
        in_gray  = 4'b0001;
        in_last  = 1'b1;
        recv("single", 16'h0009, 3'd1, 1'b0, 14'd9, 10);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
        recv("after_bp", 16'h0001, 3'd1, 1'b0, 14'd1, 0);

        // Full word without last: 3,0,5,1
        send_digit(4'b0010, 1'b0);
        measure_in_ready(lat);
        check("ready_latency", 64'(lat), 64'd5);
        send_digit(4'b0000, 1'b0);
        send_digit(4'b0111, 1'b0);
        send_digit(4'b0001, 1'b0);
        recv("full", 16'h3051, 3'd4, 1'b0, 14'd3051, 0);

        // Invalid middle code: 3, invalid, 4 with last
        send_digit(4'b0010, 1'b0);
        send_digit(4'b1111, 1'b0);
        send_digit(4'b0110, 1'b1);
        recv("invalid", 16'h03F4, 3'd3, 1'b1, 14'd0, 0);

        // Gray 0011 decodes to 2
        send_digit(4'b0011, 1'b0);
        send_digit(4'b1100, 1'b1);
        recv("two_eight", 16'h0028, 3'd2, 1'b0, 14'd28, 0);

        // Reset during the 2nd decode cycle of the 2nd digit
        send_digit(4'b0001, 1'b0);
        send_digit(4'b0011, 1'b0);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("midrst_in_ready",  64'(in_ready), 64'd1);
        check("midrst_out_valid", 64'(out_valid), 64'd0);
        check("midrst_out_bcd",   64'(out_bcd), 64'd0);
        check("midrst_out_nd",    64'(out_ndigits), 64'd0);
        check("midrst_out_err",   64'(out_err), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        send_digit(4'b0001, 1'b1);
        recv("post_rst", 16'h0001, 3'd1, 1'b0, 14'd1, 0);

        // Short word holding digit 0
        send_digit(4'b0000, 1'b1);
        recv("zero", 16'h0000, 3'd1, 1'b0, 14'd0, 0);

        // Two invalid codes followed by a completed 4-digit word
        send_digit(4'b1000, 1'b0);
        send_digit(4'b0101, 1'b0);
        send_digit(4'b0100, 1'b0);
        send_digit(4'b1010, 1'b0);
        recv("invalid4", 16'hF67F, 3'd4, 1'b1, 14'd0, 0);

        repeat (2) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
